// File: rtl/jcontrol_if.sv
// Control bundle between the jcscpu sequencer and the datapath.
// The master side decodes ir/flags and drives the strobes.
interface jcontrol_if;
  logic [7:0] ir;
  logic [3:0] flags;
  logic [6:0] step;
  logic [3:0] en_reg;
  logic [3:0] set_reg;
  logic       en_ram;
  logic       set_ram;
  logic       en_acc;
  logic       set_acc;
  logic       set_tmp;
  logic       en_iar;
  logic       set_iar;
  logic       set_mar;
  logic       set_ir;
  logic       set_flags;
  logic       bus1;
  logic [2:0] alu_op;

  modport master (
    input  ir, flags,
    output step, en_reg, set_reg, en_ram, set_ram, en_acc, set_acc, set_tmp,
           en_iar, set_iar, set_mar, set_ir, set_flags, bus1, alu_op
  );

  modport slave (
    output ir, flags,
    input  step, en_reg, set_reg, en_ram, set_ram, en_acc, set_acc, set_tmp,
           en_iar, set_iar, set_mar, set_ir, set_flags, bus1, alu_op
  );
endinterface

// File: rtl/jcontrol.sv
// jcscpu control sequencer: internal step/phase timing plus a combinational
// decode of step, ir and flags into bus enables and register set strobes.
module jcontrol #(
  parameter int LAST_STEP = 6
) (
  input logic        clk,
  input logic        reset,
  jcontrol_if.master ctl
);
  logic [2:0] stp;
  logic [1:0] ph;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stp <= 3'd1;
      ph  <= 2'd0;
    end else begin
      ph <= ph + 2'd1;
      if (ph == 2'd3)
        stp <= (stp == 3'(LAST_STEP)) ? 3'd1 : stp + 3'd1;
    end
  end

  logic [1:0] ra, rb;
  logic [3:0] ra_oh, rb_oh;
  assign ra    = ctl.ir[3:2];
  assign rb    = ctl.ir[1:0];
  assign ra_oh = 4'b0001 << ra;
  assign rb_oh = 4'b0001 << rb;

  // Raw per-step selections, before phase gating
  logic [3:0] e_reg, s_reg;
  logic       e_ram, e_acc, e_iar, b1;
  logic       s_ram, s_acc, s_tmp, s_iar, s_mar, s_ir, s_flg;
  logic [2:0] op;

  always_comb begin
    e_reg = '0; s_reg = '0;
    e_ram = 1'b0; e_acc = 1'b0; e_iar = 1'b0; b1 = 1'b0;
    s_ram = 1'b0; s_acc = 1'b0; s_tmp = 1'b0; s_iar = 1'b0;
    s_mar = 1'b0; s_ir = 1'b0; s_flg = 1'b0;
    op = 3'b000;
    case (stp)
      3'd1: begin b1 = 1'b1; e_iar = 1'b1; s_mar = 1'b1; s_acc = 1'b1; end
      3'd2: begin e_ram = 1'b1; s_ir = 1'b1; end
      3'd3: begin e_acc = 1'b1; s_iar = 1'b1; end
      default: begin
        if (ctl.ir[7]) begin
          case (stp)
            3'd4: begin e_reg = rb_oh; s_tmp = 1'b1; end
            3'd5: begin e_reg = ra_oh; op = ctl.ir[6:4]; s_acc = 1'b1; s_flg = 1'b1; end
            3'd6: if (ctl.ir[6:4] != 3'b111) begin e_acc = 1'b1; s_reg = rb_oh; end
            default: ;
          endcase
        end else begin
          case (ctl.ir[6:4])
            3'b000: case (stp)       // LD
              3'd4: begin e_reg = ra_oh; s_mar = 1'b1; end
              3'd5: begin e_ram = 1'b1; s_reg = rb_oh; end
              default: ;
            endcase
            3'b001: case (stp)       // ST
              3'd4: begin e_reg = ra_oh; s_mar = 1'b1; end
              3'd5: begin e_reg = rb_oh; s_ram = 1'b1; end
              default: ;
            endcase
            3'b010: case (stp)       // DATA
              3'd4: begin b1 = 1'b1; e_iar = 1'b1; s_mar = 1'b1; s_acc = 1'b1; end
              3'd5: begin e_ram = 1'b1; s_reg = rb_oh; end
              3'd6: begin e_acc = 1'b1; s_iar = 1'b1; end
              default: ;
            endcase
            3'b011: if (stp == 3'd4) begin e_reg = rb_oh; s_iar = 1'b1; end
            3'b100: case (stp)       // JMP
              3'd4: begin e_iar = 1'b1; s_mar = 1'b1; end
              3'd5: begin e_ram = 1'b1; s_iar = 1'b1; end
              default: ;
            endcase
            3'b101: case (stp)       // JCAEZ: target word is read even when not taken
              3'd4: begin b1 = 1'b1; e_iar = 1'b1; s_mar = 1'b1; s_acc = 1'b1; end
              3'd5: begin e_acc = 1'b1; s_iar = 1'b1; end
              3'd6: begin e_ram = 1'b1; s_iar = |(ctl.ir[3:0] & ctl.flags); end
              default: ;
            endcase
            3'b110: if (stp == 3'd4) begin b1 = 1'b1; s_flg = 1'b1; end
            default: ;
          endcase
        end
      end
    endcase
  end

  logic ph_en, ph_set;
  assign ph_en  = (ph != 2'd0);
  assign ph_set = (ph == 2'd2);

  assign ctl.step      = 7'b0000001 << (stp - 3'd1);
  assign ctl.en_reg    = ph_en ? e_reg : 4'b0000;
  assign ctl.set_reg   = ph_set ? s_reg : 4'b0000;
  assign ctl.en_ram    = ph_en & e_ram;
  assign ctl.en_acc    = ph_en & e_acc;
  assign ctl.en_iar    = ph_en & e_iar;
  assign ctl.bus1      = ph_en & b1;
  assign ctl.set_ram   = ph_set & s_ram;
  assign ctl.set_acc   = ph_set & s_acc;
  assign ctl.set_tmp   = ph_set & s_tmp;
  assign ctl.set_iar   = ph_set & s_iar;
  assign ctl.set_mar   = ph_set & s_mar;
  assign ctl.set_ir    = ph_set & s_ir;
  assign ctl.set_flags = ph_set & s_flg;
  assign ctl.alu_op    = ph_en ? op : 3'b000;
endmodule

// File: tb/tb_jcontrol.sv
// Directed bench for jcontrol: default instance plus a LAST_STEP=4 instance
// running JMP; per-cycle outputs are captured then compared to constants.
module tb_jcontrol;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  jcontrol_if bus();
  jcontrol_if b4();

  jcontrol #(.LAST_STEP(6)) dut (.clk(clk), .reset(reset), .ctl(bus.master));
  jcontrol #(.LAST_STEP(4)) u4  (.clk(clk), .reset(reset), .ctl(b4.master));

  // {en_ram,set_ram,en_acc,set_acc,set_tmp,en_iar,set_iar,set_mar,set_ir,set_flags,bus1}
  logic [10:0] cw, cw4;
  assign cw  = {bus.en_ram, bus.set_ram, bus.en_acc, bus.set_acc, bus.set_tmp, bus.en_iar,
                bus.set_iar, bus.set_mar, bus.set_ir, bus.set_flags, bus.bus1};
  assign cw4 = {b4.en_ram, b4.set_ram, b4.en_acc, b4.set_acc, b4.set_tmp, b4.en_iar,
                b4.set_iar, b4.set_mar, b4.set_ir, b4.set_flags, b4.bus1};

  logic [10:0] ctl_a [40];
  logic [6:0]  st_a  [40];
  logic [3:0]  er_a  [40];
  logic [3:0]  sr_a  [40];
  logic [2:0]  op_a  [40];
  logic [10:0] ctl4_a[40];
  logic [6:0]  st4_a [40];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reset for one edge, release with the given instruction, capture n cycles
  task automatic run(input logic [7:0] i, input logic [3:0] f, input int n);
    reset = 1'b0;
    bus.ir = i;
    bus.flags = f;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      ctl_a[c] = cw;  st_a[c] = bus.step; er_a[c] = bus.en_reg;
      sr_a[c] = bus.set_reg; op_a[c] = bus.alu_op;
      ctl4_a[c] = cw4; st4_a[c] = b4.step;
    end
  endtask

  initial begin
    logic [6:0] one;
    logic [3:0] acc;
    logic [10:0] acw;
    one = 7'b0000001;
    bus.ir = 8'h00; bus.flags = 4'h0;
    b4.ir = 8'h40;  b4.flags = 4'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_step", 32'(bus.step), 32'h01);
    chk("rst_ctl", 32'(cw), 32'h0);
    chk("rst_regs", 32'({bus.en_reg, bus.set_reg, bus.alu_op}), 32'h0);

    // LD R0,R0: step sequence, set_mar timing, fetch strobes
    run(8'h00, 4'h0, 25);
    for (int c = 0; c < 25; c++)
      chk($sformatf("ld_step_c%0d", c), 32'(st_a[c]), 32'(one << ((c / 4) % 6)));
    for (int c = 0; c < 24; c++)
      chk($sformatf("ld_setmar_c%0d", c), 32'(ctl_a[c][3]), 32'((c == 2) || (c == 14)));
    chk("fetch_c0", 32'(ctl_a[0]), 32'h000);
    chk("fetch_c1", 32'(ctl_a[1]), 32'h021);
    chk("fetch_c2", 32'(ctl_a[2]), 32'h0A9);
    chk("fetch_c6", 32'(ctl_a[6]), 32'h404);
    chk("fetch_c10", 32'(ctl_a[10]), 32'h110);
    chk("ld_c13_ctl", 32'(ctl_a[13]), 32'h000);
    chk("ld_c13_enreg", 32'(er_a[13]), 32'h1);
    chk("ld_c18_ctl", 32'(ctl_a[18]), 32'h400);
    chk("ld_c18_setreg", 32'(sr_a[18]), 32'h1);

    // ADD R1,R2
    run(8'h86, 4'h0, 24);
    chk("add_c14_ctl", 32'(ctl_a[14]), 32'h040);
    chk("add_c14_enreg", 32'(er_a[14]), 32'h4);
    chk("add_c18_ctl", 32'(ctl_a[18]), 32'h082);
    chk("add_c18_op", 32'(op_a[18]), 32'h0);
    chk("add_c18_enreg", 32'(er_a[18]), 32'h2);
    chk("add_c22_ctl", 32'(ctl_a[22]), 32'h100);
    chk("add_c22_setreg", 32'(sr_a[22]), 32'h4);
    chk("add_c21_setreg", 32'(sr_a[21]), 32'h0);

    // CMP: flags written, destination not
    run(8'hF6, 4'h0, 24);
    chk("cmp_c18_ctl", 32'(ctl_a[18]), 32'h082);
    chk("cmp_c18_op", 32'(op_a[18]), 32'h7);
    chk("cmp_c17_op", 32'(op_a[17]), 32'h7);
    chk("cmp_c16_op", 32'(op_a[16]), 32'h0);
    acc = '0;
    for (int c = 0; c < 24; c++) acc |= sr_a[c];
    chk("cmp_setreg_all", 32'(acc), 32'h0);
    chk("cmp_c22_ctl", 32'(ctl_a[22]), 32'h000);

    // JCAEZ taken / not taken
    run(8'h52, 4'b0010, 24);
    chk("jc_hit_c22_ctl", 32'(ctl_a[22]), 32'h410);
    chk("jc_hit_enram", 32'({ctl_a[20][10], ctl_a[21][10], ctl_a[22][10], ctl_a[23][10]}), 32'b0111);
    chk("jc_hit_c17_ctl", 32'(ctl_a[17]), 32'h100);
    run(8'h52, 4'b0001, 24);
    chk("jc_miss_c22_ctl", 32'(ctl_a[22]), 32'h400);
    chk("jc_miss_enram", 32'({ctl_a[20][10], ctl_a[21][10], ctl_a[22][10], ctl_a[23][10]}), 32'b0111);

    // ST R2,R3 / DATA R3 / JMPR R1 / CLF / IO
    run(8'h1B, 4'h0, 24);
    chk("st_c14_ctl", 32'(ctl_a[14]), 32'h008);
    chk("st_c14_enreg", 32'(er_a[14]), 32'h4);
    chk("st_c18_ctl", 32'(ctl_a[18]), 32'h200);
    chk("st_c18_enreg", 32'(er_a[18]), 32'h8);
    run(8'h23, 4'h0, 24);
    chk("data_c14_ctl", 32'(ctl_a[14]), 32'h0A9);
    chk("data_c18_ctl", 32'(ctl_a[18]), 32'h400);
    chk("data_c18_setreg", 32'(sr_a[18]), 32'h8);
    chk("data_c22_ctl", 32'(ctl_a[22]), 32'h110);
    run(8'h31, 4'h0, 24);
    chk("jmpr_c14_ctl", 32'(ctl_a[14]), 32'h010);
    chk("jmpr_c14_enreg", 32'(er_a[14]), 32'h2);
    run(8'h60, 4'h0, 24);
    chk("clf_c13_ctl", 32'(ctl_a[13]), 32'h001);
    chk("clf_c14_ctl", 32'(ctl_a[14]), 32'h003);
    run(8'h70, 4'h0, 24);
    acw = '0; acc = '0;
    for (int c = 12; c < 24; c++) begin acw |= ctl_a[c]; acc |= er_a[c] | sr_a[c]; end
    chk("io_exec_ctl", 32'(acw), 32'h0);
    chk("io_exec_regs", 32'(acc), 32'h0);

    // LAST_STEP=4 JMP: wraps after 16 cycles, set_iar only from fetch s3
    run(8'h00, 4'h0, 33);
    chk("l4_c12_step", 32'(st4_a[12]), 32'h08);
    chk("l4_c16_step", 32'(st4_a[16]), 32'h01);
    chk("l4_c32_step", 32'(st4_a[32]), 32'h01);
    chk("l4_c14_ctl", 32'(ctl4_a[14]), 32'h028);
    for (int c = 0; c < 33; c++)
      chk($sformatf("l4_setiar_c%0d", c), 32'(ctl4_a[c][4]), 32'((c % 16) == 10));

    // Reset at cycle 17 of ADD
    run(8'h86, 4'h0, 17);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rmid_c17_step", 32'(bus.step), 32'h10);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rmid_c18_step", 32'(bus.step), 32'h01);
    chk("rmid_c18_ctl", 32'(cw), 32'h000);
    chk("rmid_c18_regs", 32'({bus.en_reg, bus.set_reg, bus.alu_op}), 32'h0);
    @(negedge clk);
    chk("rmid_c19_ctl", 32'(cw), 32'h021);
    @(negedge clk);
    chk("rmid_c20_ctl", 32'(cw), 32'h0A9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
